// File: rtl/act_out_pack.sv
// Activation output packer: gathers int8 samples into LANES-wide words and
// queues them in a small first-word-fall-through FIFO for the consumer.
//
// Handshake: a word leaves the FIFO on any rising edge where out_vld and
// out_rdy are both 1. out_vld depends only on FIFO occupancy, never on
// out_rdy. The head word stays stable while out_vld=1 and out_rdy=0. The
// input side has no backpressure: every in_vld cycle is consumed.
module act_out_pack #(
  parameter int LANES = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  input  logic [7:0]               in_data,
  input  logic                     flush,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [8*LANES-1:0]       out_data,
  output logic [4:0]               out_nlanes,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int WW = 8 * LANES;

  logic [LW-1:0]  lcnt;
  logic [WW-1:0]  asm_q;
  logic [WW-1:0]  word_next;
  logic [4:0]     n_eff;
  logic           full_push;
  logic           flush_push;
  logic           push;
  logic           pop;
  logic           wr_en;
  logic           drop;

  logic [WW-1:0]  mem_data [DEPTH];
  logic [4:0]     mem_n    [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    cnt;

  // Assembly word including this cycle's sample, plus push decisions.
  always_comb begin
    word_next = asm_q;
    for (int k = 0; k < LANES; k++) begin
      if (in_vld && (lcnt == LW'(k))) word_next[8*k +: 8] = in_data;
    end
    // Lanes holding real data if the word were closed at this edge;
    // equals LANES exactly when the last lane is being written.
    n_eff      = 5'(lcnt) + 5'(in_vld);
    full_push  = in_vld && (lcnt == LW'(LANES - 1));
    flush_push = flush && (n_eff != 5'd0);
    push       = full_push || flush_push;
    pop        = out_vld && out_rdy;
    // A full FIFO still accepts a word when the head leaves at the same edge.
    wr_en      = push && ((cnt != (PW+1)'(DEPTH)) || pop);
    drop       = push && !wr_en;
  end

  // Lane counter and assembly register; cleared on every push, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt  <= '0;
      asm_q <= '0;
    end else if (push) begin
      lcnt  <= '0;
      asm_q <= '0;
    end else if (in_vld) begin
      lcnt  <= lcnt + LW'(1);
      asm_q <= word_next;
    end
  end

  // FIFO storage; contents are only observed through the gated head below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= word_next;
      mem_n[wr_ptr]    <= n_eff;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Head presentation; zeroed while empty so reset shows all-zero outputs.
  always_comb begin
    out_vld    = (cnt != '0);
    fifo_cnt   = cnt;
    out_data   = out_vld ? mem_data[rd_ptr] : '0;
    out_nlanes = out_vld ? mem_n[rd_ptr]    : 5'd0;
  end

endmodule

// File: tb/tb_act_out_pack.sv
// Bench for act_out_pack (LANES=8, DEPTH=4): a queue-based model of the
// packer plus FIFO, checked every cycle, and literal checks on known words.
module tb_act_out_pack;

  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int WW    = 8 * LANES;
  localparam int W     = WW + 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic [7:0]    in_data;
  logic          flush;
  logic          out_vld;
  logic          out_rdy;
  logic [WW-1:0] out_data;
  logic [4:0]    out_nlanes;
  logic [2:0]    fifo_cnt;
  logic          ovf;
  logic          ovf_clr;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: stored words as {nlanes, data}, pending samples, overflow.
  logic [W-1:0] exp_q[$];
  logic [7:0]   part[$];
  logic         m_ovf = 1'b0;

  act_out_pack #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
    .flush(flush), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_nlanes(out_nlanes), .fifo_cnt(fifo_cnt),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pop first, then collect sample, then close the word if due.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      part.delete();
      m_ovf = 1'b0;
    end else begin
      logic [W-1:0] w;
      bit drop;
      drop = 0;
      if (out_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_vld) part.push_back(in_data);
      if (part.size() == LANES || (flush && part.size() > 0)) begin
        w = '0;
        for (int k = 0; k < part.size(); k++) w[8*k +: 8] = part[k];
        w[W-1 -: 5] = 5'(part.size());
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else drop = 1;
        part.delete();
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    chk("out_vld", 128'(out_vld), 128'(exp_q.size() > 0));
    chk("fifo_cnt", 128'(fifo_cnt), 128'(exp_q.size()));
    chk("ovf", 128'(ovf), 128'(m_ovf));
    if (exp_q.size() > 0) begin
      chk("out_data", 128'(out_data), 128'(exp_q[0][WW-1:0]));
      chk("out_nlanes", 128'(out_nlanes), 128'(exp_q[0][W-1 -: 5]));
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    in_vld  = 1'b1;
    in_data = b;
    cyc();
    in_vld  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; flush = 1'b0;
    out_rdy = 1'b0; ovf_clr = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_out_vld", 128'(out_vld), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_nlanes", 128'(out_nlanes), 128'(0));
    chk("rst_fifo_cnt", 128'(fifo_cnt), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    cyc();
    rst_n = 1'b1;
    cyc();

    // One full word with the consumer always ready
    out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i));
    @(negedge clk);
    chk("full_word_vld", 128'(out_vld), 128'(1));
    chk("full_word_data", 128'(out_data), 128'(64'h0807060504030201));
    chk("full_word_nlanes", 128'(out_nlanes), 128'(8));
    cyc();
    @(negedge clk);
    chk("full_word_one_cycle", 128'(out_vld), 128'(0));

    // Partial word closed by a lone flush; a second flush adds nothing
    send(8'h81); send(8'h7F); send(8'hFF);
    flush = 1'b1; cyc(); flush = 1'b0;
    @(negedge clk);
    chk("flush_data", 128'(out_data), 128'(64'h0000000000FF7F81));
    chk("flush_nlanes", 128'(out_nlanes), 128'(3));
    flush = 1'b1; cyc(); flush = 1'b0;
    @(negedge clk);
    chk("flush_empty_vld", 128'(out_vld), 128'(0));
    chk("flush_empty_cnt", 128'(fifo_cnt), 128'(0));

    // Five words into a stalled FIFO; clear coincides with the drop
    out_rdy = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 40) ovf_clr = 1'b1;
      send(8'(i));
      ovf_clr = 1'b0;
    end
    @(negedge clk);
    chk("ovf_cnt", 128'(fifo_cnt), 128'(4));
    chk("ovf_set_wins", 128'(ovf), 128'(1));
    chk("ovf_head", 128'(out_data), 128'(64'h0807060504030201));
    out_rdy = 1'b1;
    repeat (4) cyc();
    out_rdy = 1'b0;
    @(negedge clk);
    chk("ovf_drained", 128'(fifo_cnt), 128'(0));
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 128'(ovf), 128'(0));

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 39; i++) send(8'($urandom_range(0, 255)));
    in_vld = 1'b1; in_data = 8'hC3; out_rdy = 1'b1;
    cyc();
    in_vld = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    chk("full_pushpop_cnt", 128'(fifo_cnt), 128'(4));
    chk("full_pushpop_ovf", 128'(ovf), 128'(0));
    chk("full_pushpop_last_lane", 128'(exp_q[3][63:56]), 128'(8'hC3));
    out_rdy = 1'b1;
    repeat (4) cyc();

    // Reset in the middle of a word
    for (int i = 0; i < 5; i++) send(8'hEE);
    rst_n = 1'b0; cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    @(negedge clk);
    chk("rst_mid_data", 128'(out_data), 128'(64'h1716151413121110));
    chk("rst_mid_nlanes", 128'(out_nlanes), 128'(8));
    cyc();

    // Flush together with the eighth sample yields exactly one word
    out_rdy = 1'b0;
    for (int i = 0; i < 7; i++) send(8'(8'hA0 + i));
    in_vld = 1'b1; in_data = 8'hA7; flush = 1'b1;
    cyc();
    in_vld = 1'b0; flush = 1'b0;
    cyc();
    @(negedge clk);
    chk("flush8_cnt", 128'(fifo_cnt), 128'(1));
    chk("flush8_nlanes", 128'(out_nlanes), 128'(8));
    chk("flush8_data", 128'(out_data), 128'(64'hA7A6A5A4A3A2A1A0));

    // Flush in the same cycle as a sample counts that sample
    send(8'h55); send(8'hAA);
    in_vld = 1'b1; in_data = 8'h33; flush = 1'b1;
    cyc();
    in_vld = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_vld_cnt", 128'(fifo_cnt), 128'(2));
    chk("flush_vld_word", 128'(exp_q[1]), 128'({5'd3, 64'h000000000033AA55}));
    out_rdy = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("final_empty", 128'(fifo_cnt), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/act_out_pack.md
ACT_OUT_PACK -- requirements
Module: act_out_pack

Interface
REQ-001 Parameter LANES, default 8, int8 lanes per output word (2..16).
REQ-002 Parameter DEPTH, default 4, output FIFO depth in words (power of 2, >=2).
REQ-003 Clocking SHALL be one clock, clk, with reset rst_n asynchronous and active-low.
REQ-004 Port list, in order:
 clk  input  1  clock, rising edge
 rst_n  input  1  async active-low reset
 in_vld  input  1  activation sample valid, from GELU stage out_vld
 in_data  input  8  signed int8 activation, from GELU stage y_reg1
 flush  input  1  close current partial word, zero-pad
 out_vld  output  1  FIFO head valid
 out_rdy  input  1  consumer accepts head
 out_data  output  8*LANES  packed word; lane k at bits [8k+7:8k]
 out_nlanes  output  5  lanes holding real data (1..LANES)
 fifo_cnt  output  log2(DEPTH)+1  words stored
 ovf  output  1  sticky overflow flag
 ovf_clr  input  1  clears ovf

Function
REQ-005 Upstream has no backpressure: every cycle with in_vld=1 SHALL consume in_data.
REQ-006 Lane counter lcnt (0..LANES-1) SHALL select the write lane; accepted sample k of a word goes to lane k.
REQ-007 Sample accepted with lcnt=LANES-1 SHALL push the word (including that sample) into the FIFO at the same edge, out_nlanes=LANES, lcnt wraps to 0.
REQ-008 flush=1 with effective lane count n>0 (n=lcnt plus 1 if in_vld same cycle) SHALL push one word at that edge with unfilled lanes 0 and out_nlanes=n; lcnt->0.
REQ-009 flush=1 with n=0 SHALL be a no-op; flush coinciding with a full-word push (REQ-007) SHALL produce exactly one push.
REQ-010 Assembly register SHALL be cleared to 0 at every push, so padding lanes are always 0x00.
REQ-011 FIFO SHALL be first-word-fall-through: out_vld=1 iff fifo_cnt>0; out_data/out_nlanes show the head.
REQ-012 Latency: word pushed at edge E SHALL appear on out_vld after E (visible the cycle following the last sample), if the FIFO was empty.
REQ-013 Pop SHALL occur on out_vld & out_rdy; head SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-014 Push and pop in the same cycle SHALL both succeed, fifo_cnt unchanged, even when fifo_cnt=DEPTH.
REQ-015 Push with fifo_cnt=DEPTH and no same-cycle pop SHALL drop the word, set ovf=1, leave FIFO contents intact; lcnt still resets to 0.
REQ-016 ovf SHALL stay 1 until ovf_clr=1; ovf_clr with a same-cycle overflow SHALL leave ovf=1 (set wins).
REQ-017 Read/write pointers SHALL wrap modulo DEPTH; fifo_cnt SHALL never exceed DEPTH nor go below 0.
REQ-018 Data SHALL be passed bit-exact (no sign change, no saturation).

Reset
REQ-019 rst_n=0 SHALL asynchronously set lcnt=0, assembly register=0, FIFO empty, out_vld=0, out_data=0, out_nlanes=0, fifo_cnt=0, ovf=0.
REQ-020 Reset mid-word SHALL discard the partial word; first sample after release goes to lane 0.

Verification
REQ-021 LANES=8, out_rdy=1, in_vld for 8 cycles with 0x01..0x08 -> one word 0x0807060504030201, out_nlanes=8, out_vld for one cycle.
REQ-022 3 samples 0x81,0x7F,0xFF then flush alone -> out_data=0x0000000000FF7F81, out_nlanes=3; second flush -> no word.
REQ-023 out_rdy=0, 5 full words (DEPTH=4) -> fifo_cnt=4, ovf=1, first 4 words drain in order when out_rdy=1, 5th absent.
REQ-024 fifo_cnt=4, 5th word push same cycle as out_rdy=1 -> no drop, ovf=0, fifo_cnt stays 4.
REQ-025 rst_n low after 5 samples, release, 8 samples 0x10..0x17 -> single word 0x1716151413121110, no stale lanes.
REQ-026 in_vld on 8th sample with flush=1 -> exactly one word, out_nlanes=8; ovf set then ovf_clr -> ovf=0 next cycle.
